// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin arbiter driving the select and one-hot grant of an 8:1 datapath mux.
// Optional stall timeout with err pulse is enabled by defining ARB_TIMEOUT_EN.
`default_nettype none

module mux_select_arbiter #(
   parameter int MAX_HOLD = 4
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT  = 16
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_i,
   input  logic [7:0] lock_i,
   input  logic       out_ready_i,
   output logic [7:0] grant_o,
   output logic [2:0] sel_o,
   output logic       out_valid_o
`ifdef ARB_TIMEOUT_EN
   ,
   output logic       err_o
`endif
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;
   localparam logic [4:0] C_MAX_HOLD = 5'(MAX_HOLD);

   logic [0:0] state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] rr_ptr_q, rr_ptr_d;
   logic [3:0] hold_cnt_q, hold_cnt_d;

   logic       w_in_grant;
   logic       w_valid;
   logic       w_xfer;
   logic [4:0] w_hold_inc;
   logic       w_keep;
   logic       w_timeout;
   logic       w_release;
   logic [2:0] w_start;
   logic [7:0] w_vec;
   logic [2:0] w_idx;
   logic       w_found;
   logic [2:0] w_win;

   assign w_in_grant = (state_q == S_GRANT);
   assign w_valid    = w_in_grant & req_i[sel_q];
   assign w_xfer     = w_valid & out_ready_i;
   assign w_hold_inc = {1'b0, hold_cnt_q} + 5'd1;
   assign w_keep     = lock_i[sel_q] & (w_hold_inc < C_MAX_HOLD);
   assign w_release  = w_in_grant & ((w_xfer & ~w_keep) | ~req_i[sel_q] | w_timeout);

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] C_TIMEOUT_M1 = 8'(TIMEOUT - 1);

   logic [7:0] stall_cnt_q, stall_cnt_d;
   logic       err_q;
   logic       w_stall;

   assign w_stall   = w_valid & ~out_ready_i;
   assign w_timeout = w_stall & (stall_cnt_q == C_TIMEOUT_M1);

   always_comb begin
      stall_cnt_d = stall_cnt_q + 8'd1;
      if (w_release || !w_stall) begin
         stall_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 8'd0;
         err_q       <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         err_q       <= w_timeout;
      end
   end

   assign err_o = err_q;
`else
   assign w_timeout = 1'b0;
`endif

   // While granted, the search starts just past the current owner and skips it,
   // so a releasing grantee is only re-granted when nobody else is waiting.
   assign w_start = w_in_grant ? 3'(sel_q + 3'd1) : rr_ptr_q;
   assign w_vec   = w_in_grant ? (req_i & ~grant_q) : req_i;

   always_comb begin
      w_found = 1'b0;
      w_win   = 3'd0;
      w_idx   = 3'd0;
      for (int k = 0; k < 8; k++) begin
         w_idx = 3'(w_start + 3'(k));
         if (!w_found && w_vec[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (w_found) begin
               state_d    = S_GRANT;
               sel_d      = w_win;
               grant_d    = 8'(8'd1 << w_win);
               hold_cnt_d = 4'd0;
            end
         end
         default: begin
            if (w_release) begin
               rr_ptr_d   = 3'(sel_q + 3'd1);
               hold_cnt_d = 4'd0;
               if (w_found) begin
                  sel_d   = w_win;
                  grant_d = 8'(8'd1 << w_win);
               end else if (!(req_i[sel_q] && !w_timeout)) begin
                  state_d = S_IDLE;
                  grant_d = 8'd0;
               end
            end else if (w_xfer) begin
               hold_cnt_d = w_hold_inc[3:0];
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sel_q      <= 3'd0;
         grant_q    <= 8'd0;
         rr_ptr_q   <= 3'd0;
         hold_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign grant_o     = grant_q;
   assign sel_o       = sel_q;
   assign out_valid_o = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_select_arbiter.sv
// Directed table-driven bench for mux_select_arbiter (default MAX_HOLD=4, TIMEOUT=16).
`default_nettype none

module tb_mux_select_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] lock;
   logic       out_ready;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       out_valid;
`ifdef ARB_TIMEOUT_EN
   logic       err;
`endif

   int checks = 0;
   int errors = 0;

   mux_select_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req),
      .lock_i      (lock),
      .out_ready_i (out_ready),
      .grant_o     (grant),
      .sel_o       (sel),
      .out_valid_o (out_valid)
`ifdef ARB_TIMEOUT_EN
      ,
      .err_o       (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] lock;
      logic       rdy;
      logic [7:0] g;
      logic [2:0] s;
      logic       v;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] lk, input logic rd,
                      input logic [7:0] g, input logic [2:0] s, input logic v);
      vec_t t;
      t.rst = r; t.req = rq; t.lock = lk; t.rdy = rd; t.g = g; t.s = s; t.v = v;
      vecs.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      req = 8'h00; lock = 8'h00; out_ready = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req = 8'h00; lock = 8'h00; out_ready = 1'b0;
      #2;
      chk("reset grant", 32'(grant), 32'h0);
      chk("reset sel", 32'(sel), 32'h0);
      chk("reset valid", 32'(out_valid), 32'h0);
`ifdef ARB_TIMEOUT_EN
      chk("reset err", 32'(err), 32'h0);
`endif

      // rst, req, lock, rdy | grant, sel, valid (state before the following edge)
      // single requester 2, re-grant, withdrawal to IDLE, then rr_ptr=3 governs next pick
      add(1, 8'h04, 8'h00, 1, 8'h00, 3'd0, 0);
      add(0, 8'h04, 8'h00, 1, 8'h04, 3'd2, 1);
      add(0, 8'h04, 8'h00, 1, 8'h04, 3'd2, 1);
      add(0, 8'h00, 8'h00, 1, 8'h04, 3'd2, 0);
      add(0, 8'hFF, 8'h00, 1, 8'h00, 3'd2, 0);
      add(0, 8'hFF, 8'h00, 1, 8'h08, 3'd3, 1);
      // all requesting, no lock: 0..7 then wrap to 0, no bubbles
      add(1, 8'hFF, 8'h00, 1, 8'h00, 3'd0, 0);
      for (int i = 0; i < 9; i++)
         add(0, 8'hFF, 8'h00, 1, 8'(8'd1 << (i % 8)), 3'(i % 8), 1);
      // lock on 0 capped at 4 beats, then 3 once, then back to 0
      add(1, 8'h09, 8'h01, 1, 8'h00, 3'd0, 0);
      for (int i = 0; i < 4; i++)
         add(0, 8'h09, 8'h01, 1, 8'h01, 3'd0, 1);
      add(0, 8'h09, 8'h01, 1, 8'h08, 3'd3, 1);
      add(0, 8'h09, 8'h01, 1, 8'h01, 3'd0, 1);
      // stall on 5 for 10 cycles, req[1] rising mid-stall does not preempt
      add(1, 8'h20, 8'h00, 0, 8'h00, 3'd0, 0);
      for (int i = 0; i < 10; i++)
         add(0, (i < 3) ? 8'h20 : 8'h22, 8'h00, 0, 8'h20, 3'd5, 1);
      add(0, 8'h22, 8'h00, 1, 8'h20, 3'd5, 1);
      add(0, 8'h02, 8'h00, 1, 8'h02, 3'd1, 1);
      add(0, 8'h00, 8'h00, 1, 8'h02, 3'd1, 0);
      add(0, 8'h00, 8'h00, 1, 8'h00, 3'd1, 0);
      // withdrawal on 6: valid drops at once, next pick searches from 7
      add(1, 8'h40, 8'h00, 0, 8'h00, 3'd0, 0);
      add(0, 8'h40, 8'h00, 0, 8'h40, 3'd6, 1);
      add(0, 8'h89, 8'h00, 0, 8'h40, 3'd6, 0);
      add(0, 8'h09, 8'h00, 0, 8'h80, 3'd7, 0);
      add(0, 8'h09, 8'h00, 0, 8'h01, 3'd0, 1);

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         req = vecs[i].req; lock = vecs[i].lock; out_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].g));
         chk($sformatf("v%0d sel", i), 32'(sel), 32'(vecs[i].s));
         chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].v));
         step();
      end

      // asynchronous reset in the middle of a burst
      do_reset();
      req = 8'hFF; out_ready = 1'b1;
      step(); step(); step();
      chk("burst grant", 32'(grant), 32'h04);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async rst grant", 32'(grant), 32'h0);
      chk("async rst sel", 32'(sel), 32'h0);
      chk("async rst valid", 32'(out_valid), 32'h0);
      step();
      chk("held rst grant", 32'(grant), 32'h0);
      rst_n = 1'b1;
      step();
      chk("post rst grant", 32'(grant), 32'h01);

`ifdef ARB_TIMEOUT_EN
      do_reset();
      req = 8'h18; out_ready = 1'b0;
      step();
      chk("to grant3", 32'(grant), 32'h08);
      for (int i = 1; i <= 15; i++) begin
         step();
         chk($sformatf("to stall%0d err", i), 32'(err), 32'h0);
         chk($sformatf("to stall%0d grant", i), 32'(grant), 32'h08);
      end
      step();
      chk("to err pulse", 32'(err), 32'h1);
      chk("to moved grant", 32'(grant), 32'h10);
      step();
      chk("to err clear", 32'(err), 32'h0);
      chk("to new grant", 32'(grant), 32'h10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
